cache_control_nway: RTL and testbench

- Control FSM for a parametrised N-way set-associative, write-back, write-allocate cache between the CPU memory port and physical memory.
- Successor to the fixed 2-way controller. It holds per-set tree pseudo-LRU state internally and prefers invalid ways when choosing a victim.
- After a fill it re-runs the tag check so the access completes as a hit.
- It drives one-hot load strobes into the tag/valid/dirty/data arrays and selects the pmem address and data source through the datapath muxes.

---
 rtl/cache_control_nway.sv | 197 +++++++++++++++++++
 tb/tb_cache_control_nway.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative, write-back, write-allocate cache.
// Keeps per-set tree pseudo-LRU state internally. Victim choice prefers the
// lowest invalid way; if every way is valid, the tree points at the victim.
// After a fill the tag check runs again, so every access ends as a hit.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   mem_read/write    CPU request, held until mem_resp (both set = write)
//   set_idx           set index of the CPU address
//   hit/valid/dirty   per-way status of the indexed set
//   pmem_resp         physical memory transfer complete
//   mem_resp          one-cycle completion pulse to the CPU
//   pmem_read/write   line fill / write-back requests
//   pmem_addr_sel     0 = CPU line address, 1 = {stored tag of way_sel, set_idx}
//   way_sel           way steering the datapath read and write-back muxes
//   data_in_sel       0 = CPU write-merge data, 1 = pmem line
//   load_*            one-hot array write strobes
//   dirty_in          value written to the dirty bit
module cache_control_nway #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [$clog2(SETS)-1:0] set_idx,
  input  logic [WAYS-1:0]         hit,
  input  logic [WAYS-1:0]         valid,
  input  logic [WAYS-1:0]         dirty,
  input  logic                    pmem_resp,
  output logic                    mem_resp,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic                    pmem_addr_sel,
  output logic [$clog2(WAYS)-1:0] way_sel,
  output logic                    data_in_sel,
  output logic [WAYS-1:0]         load_data,
  output logic [WAYS-1:0]         load_tag,
  output logic [WAYS-1:0]         load_valid,
  output logic [WAYS-1:0]         load_dirty,
  output logic                    dirty_in
);

  localparam int unsigned WayW  = $clog2(WAYS);
  localparam int unsigned Nodes = WAYS - 1;

  typedef enum logic [1:0] {StIdle, StTagCheck, StWriteback, StFill} state_e;

  state_e          state_q, state_d;
  logic [WayW-1:0] victim_q, victim_d;
  logic [Nodes-1:0] plru_q [SETS];

  logic [Nodes-1:0] plru_cur, plru_new;
  logic             plru_we;
  logic [WayW-1:0]  hit_way, inv_way, plru_way, miss_way, upd_sh;
  logic [WAYS-1:0]  hit_oh, vic_oh;
  logic             req, walk_bit, upd_bit;
  int               walk_node, upd_node;

  assign req      = mem_read | mem_write;
  assign plru_cur = plru_q[set_idx];
  assign hit_oh   = WAYS'(1) << hit_way;
  assign vic_oh   = WAYS'(1) << victim_q;
  assign miss_way = (&valid) ? plru_way : inv_way;

  // Lowest-index hit way and lowest-index invalid way.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i])   hit_way = WayW'(i);
      if (!valid[i]) inv_way = WayW'(i);
    end
  end

  // Walk the tree from the root; a node bit of 1 steers to the upper half.
  always_comb begin
    walk_node = 0;
    walk_bit  = 1'b0;
    plru_way  = '0;
    for (int lvl = 0; lvl < WayW; lvl++) begin
      walk_bit = 1'b0;
      for (int n = 0; n < Nodes; n++) begin
        if (n == walk_node) walk_bit = plru_cur[n];
      end
      plru_way  = (plru_way << 1) | WayW'(walk_bit);
      walk_node = 2 * walk_node + 1 + int'(walk_bit);
    end
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    upd_node = 0;
    upd_bit  = 1'b0;
    upd_sh   = '0;
    plru_new = plru_cur;
    for (int lvl = 0; lvl < WayW; lvl++) begin
      upd_sh  = hit_way >> (WayW - 1 - lvl);
      upd_bit = upd_sh[0];
      for (int n = 0; n < Nodes; n++) begin
        if (n == upd_node) plru_new[n] = ~upd_bit;
      end
      upd_node = 2 * upd_node + 1 + int'(upd_bit);
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    plru_we       = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = '0;
    data_in_sel   = 1'b0;
    load_data     = '0;
    load_tag      = '0;
    load_valid    = '0;
    load_dirty    = '0;
    dirty_in      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) state_d = StTagCheck;
      end
      StTagCheck: begin
        if (!req) begin
          state_d = StIdle;
        end else if (|hit) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          plru_we  = 1'b1;
          if (mem_write) begin
            load_data  = hit_oh;
            load_dirty = hit_oh;
            dirty_in   = 1'b1;
          end
          state_d = StIdle;
        end else begin
          victim_d = miss_way;
          state_d  = (valid[miss_way] && dirty[miss_way]) ? StWriteback : StFill;
        end
      end
      StWriteback: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = StFill;
      end
      StFill: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          load_data   = vic_oh;
          load_tag    = vic_oh;
          load_valid  = vic_oh;
          load_dirty  = vic_oh;
          data_in_sel = 1'b1;
          state_d     = StTagCheck;
        end
      end
      default: state_d = StIdle;
    endcase

    // Quiet every output and suppress all updates while reset is held.
    if (reset) begin
      state_d       = StIdle;
      plru_we       = 1'b0;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      way_sel       = '0;
      data_in_sel   = 1'b0;
      load_data     = '0;
      load_tag      = '0;
      load_valid    = '0;
      load_dirty    = '0;
      dirty_in      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (plru_we) plru_q[set_idx] <= plru_new;
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
module tb_cache_control_nway;

  localparam int W = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       reset, mem_read, mem_write, pmem_resp;
  logic [2:0] set_idx;
  logic [3:0] hit, valid, dirty;
  logic       mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, dirty_in;
  logic [1:0] way_sel;
  logic [3:0] load_data, load_tag, load_valid, load_dirty;
  logic [23:0] obs;

  int total = 0;
  int bad   = 0;
  int m_plru [S][W-1];

  cache_control_nway #(.WAYS(W), .SETS(S)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit(hit), .valid(valid), .dirty(dirty), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .data_in_sel(data_in_sel),
    .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .dirty_in(dirty_in)
  );

  always #5 clk = ~clk;

  assign obs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_in_sel,
                load_data, load_tag, load_valid, load_dirty, dirty_in};

  typedef struct {
    logic       rst, rd, wr;
    logic [2:0] st;
    logic [3:0] ht, vl, dt;
    logic       pr;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] ex(input logic resp, input logic prd, input logic pwr,
                                     input logic asel, input logic [1:0] ws, input logic dsel,
                                     input logic [3:0] ld, input logic [3:0] lt,
                                     input logic [3:0] lv, input logic [3:0] ldy,
                                     input logic din);
    return {resp, prd, pwr, asel, ws, dsel, ld, lt, lv, ldy, din};
  endfunction

  function automatic logic [23:0] hit_ex(input int w, input logic wr);
    logic [3:0] oh;
    oh = 4'(1 << w);
    return ex(1'b1, 1'b0, 1'b0, 1'b0, 2'(w), 1'b0, wr ? oh : 4'h0, 4'h0, 4'h0,
              wr ? oh : 4'h0, wr);
  endfunction

  function automatic logic [23:0] fill_ex(input int w, input logic resp);
    logic [3:0] oh;
    oh = resp ? 4'(1 << w) : 4'h0;
    return ex(1'b0, 1'b1, 1'b0, 1'b0, 2'(w), resp, oh, oh, oh, oh, 1'b0);
  endfunction

  function automatic logic [23:0] wb_ex(input int w);
    return ex(1'b0, 1'b0, 1'b1, 1'b1, 2'(w), 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endfunction

  function automatic vec_t mkv(input logic rst, input logic rd, input logic wr,
                               input logic [2:0] st, input logic [3:0] ht,
                               input logic [3:0] vl, input logic [3:0] dt, input logic pr,
                               input logic [23:0] e);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.st = st; v.ht = ht; v.vl = vl; v.dt = dt;
    v.pr = pr; v.exp = e;
    return v;
  endfunction

  function automatic int lowest(input logic [3:0] x);
    for (int i = 0; i < 4; i++) if (x[i]) return i;
    return 0;
  endfunction

  // Reference tree PLRU: halve the way range at each level.
  function automatic int m_victim(input int s);
    int lo, span, n;
    lo = 0; span = W; n = 0;
    while (span > 1) begin
      span = span / 2;
      if (m_plru[s][n] != 0) begin
        lo = lo + span; n = 2 * n + 2;
      end else begin
        n = 2 * n + 1;
      end
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int lo, span, n;
    lo = 0; span = W; n = 0;
    while (span > 1) begin
      span = span / 2;
      if (w >= lo + span) begin
        m_plru[s][n] = 0; lo = lo + span; n = 2 * n + 2;
      end else begin
        m_plru[s][n] = 1; n = 2 * n + 1;
      end
    end
  endtask

  // Drive one cycle's inputs just after the edge, compare just before the next.
  task automatic apply(input vec_t v, input string nm);
    reset = v.rst; mem_read = v.rd; mem_write = v.wr; set_idx = v.st;
    hit = v.ht; valid = v.vl; dirty = v.dt; pmem_resp = v.pr;
    #3;
    total++;
    if (obs !== v.exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, obs, v.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic one(input logic rst, input logic rd, input logic wr, input logic [2:0] st,
                     input logic [3:0] ht, input logic [3:0] vl, input logic [3:0] dt,
                     input logic pr, input logic [23:0] e, input string nm);
    apply(mkv(rst, rd, wr, st, ht, vl, dt, pr, e), nm);
  endtask

  task automatic read_hit(input logic [2:0] st, input int w);
    one(0, 1, 0, st, 4'(1 << w), 4'hF, 4'h0, 0, 24'h0, "plru idle");
    one(0, 1, 0, st, 4'(1 << w), 4'hF, 4'h0, 0, hit_ex(w, 0), "plru hit");
  endtask

  // Clean miss with the victim the caller expects; fill resp after one wait cycle.
  task automatic read_miss(input logic [2:0] st, input logic [3:0] vl, input int vic);
    one(0, 1, 0, st, 4'h0, vl, 4'h0, 0, 24'h0, "miss idle");
    one(0, 1, 0, st, 4'h0, vl, 4'h0, 0, 24'h0, "miss tag check");
    one(0, 1, 0, st, 4'h0, vl, 4'h0, 0, fill_ex(vic, 0), "miss fill");
    one(0, 1, 0, st, 4'h0, vl, 4'h0, 1, fill_ex(vic, 1), "miss fill resp");
    one(0, 1, 0, st, 4'(1 << vic), 4'hF, 4'h0, 0, hit_ex(vic, 0), "miss refill hit");
  endtask

  task automatic rand_txn();
    logic [2:0] s;
    logic       rd, wr;
    logic [3:0] vl, dt, ht;
    int         w, vic, n;
    s  = 3'($urandom_range(0, 7));
    wr = 1'($urandom_range(0, 1));
    rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    vl = 4'($urandom);
    if ($urandom_range(0, 1) == 1) vl = 4'hF;
    dt = 4'($urandom);
    ht = 4'($urandom) & vl;
    if ($urandom_range(0, 2) == 0) ht = 4'h0;
    one(0, rd, wr, s, ht, vl, dt, 0, 24'h0, "rnd idle");
    if (ht != 4'h0) begin
      w = lowest(ht);
      one(0, rd, wr, s, ht, vl, dt, 0, hit_ex(w, wr), "rnd hit");
      m_touch(int'(s), w);
    end else begin
      vic = (vl == 4'hF) ? m_victim(int'(s)) : lowest(~vl);
      one(0, rd, wr, s, ht, vl, dt, 0, 24'h0, "rnd miss");
      if (vl[vic] && dt[vic]) begin
        n = $urandom_range(0, 3);
        repeat (n) one(0, rd, wr, s, ht, vl, dt, 0, wb_ex(vic), "rnd wb");
        one(0, rd, wr, s, ht, vl, dt, 1, wb_ex(vic), "rnd wb resp");
      end
      n = $urandom_range(0, 3);
      repeat (n) one(0, rd, wr, s, ht, vl, dt, 0, fill_ex(vic, 0), "rnd fill");
      one(0, rd, wr, s, ht, vl, dt, 1, fill_ex(vic, 1), "rnd fill resp");
      one(0, rd, wr, s, 4'(1 << vic), vl, dt, 0, hit_ex(vic, wr), "rnd refill hit");
      m_touch(int'(s), vic);
    end
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; set_idx = '0;
    hit = '0; valid = '0; dirty = '0; pmem_resp = 1'b0;
    @(posedge clk);
    #1;

    // Reset (outputs quiet even with a request pending), then directed vectors.
    tbl.push_back(mkv(1, 1, 1, 3, 4'h4, 4'hF, 4'hF, 1, 24'h0));
    tbl.push_back(mkv(0, 1, 0, 3, 4'h4, 4'hF, 4'h0, 0, 24'h0));
    tbl.push_back(mkv(0, 1, 0, 3, 4'h4, 4'hF, 4'h0, 0, hit_ex(2, 0)));
    tbl.push_back(mkv(0, 0, 0, 3, 4'h0, 4'hF, 4'h0, 0, 24'h0));
    tbl.push_back(mkv(0, 0, 1, 3, 4'h1, 4'hF, 4'h0, 0, 24'h0));
    tbl.push_back(mkv(0, 0, 1, 3, 4'h1, 4'hF, 4'h0, 0, hit_ex(0, 1)));
    tbl.push_back(mkv(0, 0, 0, 3, 4'h0, 4'hF, 4'h0, 0, 24'h0));
    tbl.push_back(mkv(0, 1, 0, 1, 4'h0, 4'hB, 4'h0, 0, 24'h0));
    tbl.push_back(mkv(0, 1, 0, 1, 4'h0, 4'hB, 4'h0, 0, 24'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(0, 1, 0, 1, 4'h0, 4'hB, 4'h0, 0, fill_ex(2, 0)));
    tbl.push_back(mkv(0, 1, 0, 1, 4'h0, 4'hB, 4'h0, 1, fill_ex(2, 1)));
    tbl.push_back(mkv(0, 1, 0, 1, 4'h4, 4'hF, 4'h0, 0, hit_ex(2, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 4'h0, 4'hF, 4'h0, 0, 24'h0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Dirty PLRU victim in untouched set 0: write-back then fill of way 0.
    one(0, 1, 0, 0, 4'h0, 4'hF, 4'h1, 0, 24'h0, "wb idle");
    one(0, 1, 0, 0, 4'h0, 4'hF, 4'h1, 0, 24'h0, "wb tag check");
    one(0, 1, 0, 0, 4'h0, 4'hF, 4'h1, 0, wb_ex(0), "wb wait");
    one(0, 1, 0, 0, 4'h0, 4'hF, 4'h1, 1, wb_ex(0), "wb resp");
    one(0, 1, 0, 0, 4'h0, 4'hF, 4'h1, 0, fill_ex(0, 0), "wb fill");
    one(0, 1, 0, 0, 4'h0, 4'hF, 4'h1, 1, fill_ex(0, 1), "wb fill resp");
    one(0, 1, 0, 0, 4'h1, 4'hF, 4'h0, 0, hit_ex(0, 0), "wb refill hit");

    // Touch ways 0..3 of set 5; PLRU then points at way 0. Set 6 is independent.
    for (int w = 0; w < 4; w++) read_hit(5, w);
    read_miss(5, 4'hF, 0);
    read_miss(6, 4'hF, 0);

    // Reset while filling: straight back to idle, no strobes.
    one(0, 1, 0, 2, 4'h0, 4'h7, 4'h0, 0, 24'h0, "rst idle");
    one(0, 1, 0, 2, 4'h0, 4'h7, 4'h0, 0, 24'h0, "rst tag check");
    one(0, 1, 0, 2, 4'h0, 4'h7, 4'h0, 0, fill_ex(3, 0), "rst fill");
    one(1, 1, 0, 2, 4'h0, 4'h7, 4'h0, 1, 24'h0, "rst in fill");
    one(0, 0, 0, 2, 4'h0, 4'h7, 4'h0, 1, 24'h0, "rst after");

    // Request dropped in fill: the fill completes, then idle without mem_resp.
    one(0, 1, 0, 2, 4'h0, 4'h7, 4'h0, 0, 24'h0, "drop idle");
    one(0, 1, 0, 2, 4'h0, 4'h7, 4'h0, 0, 24'h0, "drop tag check");
    one(0, 0, 0, 2, 4'h0, 4'h7, 4'h0, 0, fill_ex(3, 0), "drop fill");
    one(0, 0, 0, 2, 4'h0, 4'h7, 4'h0, 1, fill_ex(3, 1), "drop fill resp");
    one(0, 0, 0, 2, 4'h8, 4'hF, 4'h0, 0, 24'h0, "drop tag check 2");
    one(0, 0, 0, 2, 4'h0, 4'hF, 4'h0, 0, 24'h0, "drop idle 2");

    // Random traffic against the reference model, from a clean reset.
    one(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 24'h0, "rnd reset");
    for (int s = 0; s < S; s++) for (int n = 0; n < W - 1; n++) m_plru[s][n] = 0;
    for (int t = 0; t < 300; t++) rand_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
